// File: rtl/i2c_passthru_pkg.sv
// Shared constants and FSM encoding for the I2C pass-through bus monitor.
package i2c_passthru_pkg;

  localparam int unsigned FILT_LEN_DEF = 3;
  localparam int unsigned BYTE_BITS    = 8;
  localparam int unsigned BIT_CNT_W    = 4;
  localparam int unsigned FILT_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

endpackage

// File: rtl/i2c_passthru_bus_monitor_if.sv
// Raw master-side lines in, filtered lines and decoded bus events out.
interface i2c_passthru_bus_monitor_if;
  import i2c_passthru_pkg::*;

  logic                 i_mst_scl;
  logic                 i_mst_sda;
  logic                 o_scl_f;
  logic                 o_sda_f;
  logic                 o_start;
  logic                 o_rstart;
  logic                 o_stop;
  logic                 o_scl_rise;
  logic                 o_scl_fall;
  logic                 o_busy;
  logic [BIT_CNT_W-1:0] o_bit_cnt;
  logic                 o_ack_phase;
  logic [BYTE_BITS-1:0] o_byte;
  logic                 o_byte_vld;
  logic                 o_addr_phase;
  logic                 o_rw;
  logic                 o_rw_vld;

  modport master (
    output i_mst_scl, i_mst_sda,
    input  o_scl_f, o_sda_f, o_start, o_rstart, o_stop, o_scl_rise, o_scl_fall,
           o_busy, o_bit_cnt, o_ack_phase, o_byte, o_byte_vld, o_addr_phase,
           o_rw, o_rw_vld
  );

  modport slave (
    input  i_mst_scl, i_mst_sda,
    output o_scl_f, o_sda_f, o_start, o_rstart, o_stop, o_scl_rise, o_scl_fall,
           o_busy, o_bit_cnt, o_ack_phase, o_byte, o_byte_vld, o_addr_phase,
           o_rw, o_rw_vld
  );

endinterface

// File: rtl/i2c_passthru_glitch_filt.sv
// One line: 2-FF synchronizer, then the output follows only after FILT_LEN equal samples.
module i2c_passthru_glitch_filt
  import i2c_passthru_pkg::*;
#(
  parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_raw,
  output logic o_filt
);

  localparam logic [FILT_CNT_W-1:0] CNT_MAX = FILT_CNT_W'(FILT_LEN - 1);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_filt;
  logic [FILT_CNT_W-1:0] r_cnt;

  // Lines idle high, so reset to 1 to avoid a phantom edge on release
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_filt  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_filt <= r_sync2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + FILT_CNT_W'(1);
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/i2c_passthru_bus_monitor.sv
// Passive I2C monitor: filters SCL/SDA, decodes START/STOP, tracks bit count,
// captures bytes and the address R/W bit.
module i2c_passthru_bus_monitor
  import i2c_passthru_pkg::*;
#(
  parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
  input  logic                       clk,
  input  logic                       rstn,
  i2c_passthru_bus_monitor_if.slave  bus
);

  localparam int unsigned              SETTLE_W = 5;
  localparam logic [SETTLE_W-1:0]      SETTLE   = SETTLE_W'(FILT_LEN + 3);
  localparam logic [BIT_CNT_W-1:0]     CNT_BYTE = BIT_CNT_W'(BYTE_BITS);
  localparam logic [BIT_CNT_W-1:0]     CNT_LAST = BIT_CNT_W'(BYTE_BITS - 1);

  logic                 w_scl_f;
  logic                 w_sda_f;
  logic                 w_armed;
  logic                 w_scl_hi;
  logic                 w_start;
  logic                 w_stop;
  logic                 w_rise;
  logic                 w_fall;
  state_e               w_state_nxt;

  state_e               r_state;
  logic                 r_scl_d;
  logic                 r_sda_d;
  logic [SETTLE_W-1:0]  r_settle;
  logic                 r_start;
  logic                 r_rstart;
  logic                 r_stop;
  logic                 r_scl_rise;
  logic                 r_scl_fall;
  logic                 r_busy;
  logic                 r_addr_phase;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [BYTE_BITS-2:0] r_shift;
  logic [BYTE_BITS-1:0] r_byte;
  logic                 r_byte_vld;
  logic                 r_rw;
  logic                 r_rw_vld;
  logic                 r_ack_seen;

  i2c_passthru_glitch_filt #(.FILT_LEN(FILT_LEN)) u_filt_scl (
    .clk    (clk),
    .rstn   (rstn),
    .i_raw  (bus.i_mst_scl),
    .o_filt (w_scl_f)
  );

  i2c_passthru_glitch_filt #(.FILT_LEN(FILT_LEN)) u_filt_sda (
    .clk    (clk),
    .rstn   (rstn),
    .i_raw  (bus.i_mst_sda),
    .o_filt (w_sda_f)
  );

  // Filters restart from idle-high after reset; their first catch-up edge is not a bus event
  assign w_armed  = (r_settle == SETTLE);
  assign w_scl_hi = r_scl_d & w_scl_f;
  assign w_start  = w_armed & w_scl_hi & r_sda_d & ~w_sda_f;
  assign w_stop   = w_armed & w_scl_hi & ~r_sda_d & w_sda_f;
  assign w_rise   = ~r_scl_d & w_scl_f;
  assign w_fall   = r_scl_d & ~w_scl_f;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (r_state == ST_ADDR && w_fall && r_ack_seen) begin
      w_state_nxt = ST_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_scl_d      <= 1'b1;
      r_sda_d      <= 1'b1;
      r_settle     <= '0;
      r_start      <= 1'b0;
      r_rstart     <= 1'b0;
      r_stop       <= 1'b0;
      r_scl_rise   <= 1'b0;
      r_scl_fall   <= 1'b0;
      r_busy       <= 1'b0;
      r_addr_phase <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_byte       <= '0;
      r_byte_vld   <= 1'b0;
      r_rw         <= 1'b0;
      r_rw_vld     <= 1'b0;
      r_ack_seen   <= 1'b0;
    end else begin
      r_scl_d      <= w_scl_f;
      r_sda_d      <= w_sda_f;
      if (!w_armed) r_settle <= r_settle + SETTLE_W'(1);
      r_start      <= w_start;
      r_rstart     <= w_start & r_busy;
      r_stop       <= w_stop;
      r_scl_rise   <= w_rise;
      r_scl_fall   <= w_fall;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_addr_phase <= (w_state_nxt == ST_ADDR);
      r_byte_vld   <= 1'b0;
      if (w_start || w_stop) begin
        r_bit_cnt  <= '0;
        r_shift    <= '0;
        r_rw_vld   <= 1'b0;
        r_ack_seen <= 1'b0;
      end else if (r_busy) begin
        // Bit count holds at 8 through the ACK bit and wraps on the fall that ends it
        if (w_rise) begin
          if (r_bit_cnt < CNT_BYTE) begin
            r_shift   <= {r_shift[BYTE_BITS-3:0], w_sda_f};
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            if (r_bit_cnt == CNT_LAST) begin
              r_byte     <= {r_shift, w_sda_f};
              r_byte_vld <= 1'b1;
              if (r_state == ST_ADDR) begin
                r_rw     <= w_sda_f;
                r_rw_vld <= 1'b1;
              end
            end
          end else begin
            r_ack_seen <= 1'b1;
          end
        end else if (w_fall && r_ack_seen) begin
          r_bit_cnt  <= '0;
          r_ack_seen <= 1'b0;
        end
      end
    end
  end

  assign bus.o_scl_f      = w_scl_f;
  assign bus.o_sda_f      = w_sda_f;
  assign bus.o_start      = r_start;
  assign bus.o_rstart     = r_rstart;
  assign bus.o_stop       = r_stop;
  assign bus.o_scl_rise   = r_scl_rise;
  assign bus.o_scl_fall   = r_scl_fall;
  assign bus.o_busy       = r_busy;
  assign bus.o_bit_cnt    = r_bit_cnt;
  assign bus.o_ack_phase  = (r_bit_cnt == CNT_BYTE);
  assign bus.o_byte       = r_byte;
  assign bus.o_byte_vld   = r_byte_vld;
  assign bus.o_addr_phase = r_addr_phase;
  assign bus.o_rw         = r_rw;
  assign bus.o_rw_vld     = r_rw_vld;

endmodule

// File: doc/i2c_passthru_bus_monitor.md
I2C_PASSTHRU_BUS_MONITOR -- requirements
Module: i2c_passthru_bus_monitor

Interface
REQ-001 Parameter FILT_LEN, default 3: consecutive stable clk cycles required before a filtered line changes; legal range 1..15.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 i_mst_scl  input  1  raw master-side SCL, asynchronous.
REQ-005 i_mst_sda  input  1  raw master-side SDA, asynchronous.
REQ-006 o_scl_f / o_sda_f  output  1 each  filtered SCL / SDA.
REQ-007 o_start  output  1  one-cycle pulse on any START, including repeated START.
REQ-008 o_rstart  output  1  one-cycle pulse, coincident with o_start, only when o_busy was already 1.
REQ-009 o_stop  output  1  one-cycle pulse on STOP.
REQ-010 o_scl_rise / o_scl_fall  output  1 each  one-cycle pulses on filtered SCL edges.
REQ-011 o_busy  output  1  high from START to STOP.
REQ-012 o_bit_cnt  output  4  bits completed in current frame, 0..8.
REQ-013 o_ack_phase  output  1  high while the 9th (ACK) bit is on the bus.
REQ-014 o_byte  output  8  last completed byte, MSB first; held until the next byte completes.
REQ-015 o_byte_vld  output  1  one-cycle pulse when the 8th data bit is sampled.
REQ-016 o_addr_phase  output  1  high while the first frame after START/rSTART is in progress.
REQ-017 o_rw  output  1  R/W bit of the last address byte (1 = read); valid while o_rw_vld is 1.
REQ-018 o_rw_vld  output  1  set when the address byte completes; cleared on START or STOP.

Function
REQ-019 Each raw line passes through a 2-FF synchronizer, then a per-line stability counter; the filtered line takes the synchronized value after FILT_LEN consecutive equal samples.
REQ-020 Latency from a raw edge to the filtered edge is FILT_LEN+2 clk cycles; pulses shorter than FILT_LEN cycles are suppressed.
REQ-021 Every event output is registered and asserted exactly one cycle after the filtered-line change that causes it.
REQ-022 START: filtered SDA falls while filtered SCL is 1 in both the previous and the current cycle.
REQ-023 STOP: filtered SDA rises while filtered SCL is 1 in both the previous and the current cycle.
REQ-024 If SCL and SDA change in the same cycle, neither START nor STOP is flagged; only the SCL edge pulse is produced.
REQ-025 The FSM has states IDLE, ADDR, DATA; any START goes to ADDR; the first completed ACK bit goes ADDR->DATA; STOP goes to IDLE from any state.
REQ-026 o_busy = (state != IDLE); o_addr_phase = (state == ADDR).
REQ-027 Each SCL rise while busy and o_bit_cnt<8 shifts SDA into the shift register and increments o_bit_cnt.
REQ-028 The SCL rise with o_bit_cnt 7->8 produces o_byte_vld and loads o_byte; in ADDR, it also loads o_rw = bit0 and sets o_rw_vld.
REQ-029 o_ack_phase = (o_bit_cnt == 8).
REQ-030 The first SCL fall after the ACK-bit SCL rise wraps o_bit_cnt to 0, keeping no count above 8.
REQ-031 START or STOP mid-frame clears o_bit_cnt and the shift register; a partial byte never produces o_byte_vld.
REQ-032 SCL edges in IDLE produce o_scl_rise/o_scl_fall only; counters and the FSM are untouched.

Reset
REQ-033 While rstn=0 at a clk edge: synchronizer and filter state go to 1 (bus idle high); counters go to 0; FSM goes to IDLE.
REQ-034 During reset every output holds its reset value: o_scl_f=1, o_sda_f=1, o_byte=8'h00, o_bit_cnt=0, all other outputs 0.
REQ-035 Reset mid-transaction abandons the transaction; after release, the block waits for a fresh START, and the stale bus state produces no START.

Structure
REQ-036 Shared package i2c_passthru_pkg holds the FSM state encoding (IDLE/ADDR/DATA), the FILT_LEN default and the bit-count constant 8.
REQ-037 Sub-module i2c_passthru_glitch_filt implements one synchronizer plus stability counter and is instantiated once per line.

Verification
REQ-038 FILT_LEN=3; SDA falls with SCL high -> o_start on cycle 6 after the raw edge, o_busy=1, o_rstart=0.
REQ-039 Address 0x51 sent as a read (byte 0xA3) then an ACK -> o_byte_vld with o_byte=0xA3, o_rw=1, o_rw_vld=1, o_ack_phase for one bit, then o_addr_phase=0.
REQ-040 2-cycle SDA glitch while SCL is high -> no o_start/o_stop; o_sda_f is unchanged.
REQ-041 Repeated START after 4 data bits -> o_start and o_rstart together, o_bit_cnt=0, no o_byte_vld.
REQ-042 Data byte 0x5A, then STOP -> o_byte=0x5A, o_stop pulse, o_busy=0, o_rw_vld=0.
REQ-043 rstn low for 1 cycle in the middle of a byte -> all outputs at reset values; later SCL activity without START leaves o_busy=0.
